// File: rtl/n_bits_mult_pkg.sv
// Shared state type and sizing helpers for the sequential shift-add multiplier.
package n_bits_mult_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    function automatic int LATENCY(input int bits, input int step);
        return bits / step + 1;
    endfunction

    function automatic int CNT_WIDTH(input int bits, input int step);
        return $clog2(bits / step + 1);
    endfunction

    // Wide enough to hold any slice offset inside the 2*BITS accumulator.
    function automatic int SHIFT_WIDTH(input int bits);
        return $clog2(2 * bits);
    endfunction

endpackage

// File: rtl/n_bits_mult_step.sv
// One shift-add iteration: accumulate multiplicand times a STEP-bit multiplier slice.
module n_bits_mult_step
    import n_bits_mult_pkg::*;
#(
    parameter int BITS = 24,
    parameter int STEP = 1
) (
    input  logic [2*BITS-1:0]            acc_i,
    input  logic [BITS-1:0]              mcand_i,
    input  logic [STEP-1:0]              slice_i,
    input  logic [SHIFT_WIDTH(BITS)-1:0] shamt_i,
    output logic [2*BITS-1:0]            accNext_o
);

    logic [2*BITS-1:0] partial;

    // The true product never exceeds 2*BITS bits, so this sum cannot wrap.
    assign partial   = (2*BITS)'(mcand_i) * (2*BITS)'(slice_i);
    assign accNext_o = acc_i + (partial << shamt_i);

endmodule

// File: rtl/n_bits_seq_multiplier.sv
// Sequential shift-add multiplier with START/DONE handshake and sign-magnitude handling.
module n_bits_seq_multiplier
    import n_bits_mult_pkg::*;
#(
    parameter int BITS = 24,
    parameter int STEP = 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            START,
    input  logic            SIGNED_MODE,
    input  logic [BITS-1:0] A,
    input  logic [BITS-1:0] B,
    output logic            BUSY,
    output logic            DONE,
    output logic [BITS-1:0] RESULT,
    output logic [BITS-1:0] RESULT_HI,
    output logic            OVERFLOW
);

    localparam int N   = BITS / STEP;
    localparam int CW  = CNT_WIDTH(BITS, STEP);
    localparam int SHW = SHIFT_WIDTH(BITS);

    if (BITS < 2 || STEP < 1 || (BITS % STEP) != 0) begin : gBadParams
        $error("n_bits_seq_multiplier: BITS must be >= 2 and STEP must divide BITS");
    end

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*BITS-1:0] acc_q, acc_d;
    logic [BITS-1:0]   mcand_q, mcand_d;
    logic [BITS-1:0]   mplier_q, mplier_d;
    logic              sign_q, sign_d;
    logic              mode_q, mode_d;
    logic [BITS-1:0]   result_q, result_d;
    logic [BITS-1:0]   resultHi_q, resultHi_d;
    logic              overflow_q, overflow_d;
    logic              done_q, done_d;

    logic [2*BITS-1:0] accStep;
    logic [2*BITS-1:0] product;
    logic [SHW-1:0]    shamt;

    assign shamt = SHW'(cnt_q) * SHW'(STEP);

    n_bits_mult_step #(
        .BITS (BITS),
        .STEP (STEP)
    ) uStep (
        .acc_i     (acc_q),
        .mcand_i   (mcand_q),
        .slice_i   (mplier_q[STEP-1:0]),
        .shamt_i   (shamt),
        .accNext_o (accStep)
    );

    // Operands are held as magnitudes; the sign is restored only at the end.
    assign product = sign_q ? -acc_q : acc_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        sign_d     = sign_q;
        mode_d     = mode_q;
        result_d   = result_q;
        resultHi_d = resultHi_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (START) begin
                    mcand_d  = (SIGNED_MODE && A[BITS-1]) ? -A : A;
                    mplier_d = (SIGNED_MODE && B[BITS-1]) ? -B : B;
                    sign_d   = SIGNED_MODE & (A[BITS-1] ^ B[BITS-1]);
                    mode_d   = SIGNED_MODE;
                    cnt_d    = '0;
                    acc_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d    = accStep;
                mplier_d = mplier_q >> STEP;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                result_d   = product[BITS-1:0];
                resultHi_d = product[2*BITS-1:BITS];
                overflow_d = mode_q ? (product[2*BITS-1:BITS] != {BITS{product[BITS-1]}})
                                    : (product[2*BITS-1:BITS] != '0);
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            sign_q     <= 1'b0;
            mode_q     <= 1'b0;
            result_q   <= '0;
            resultHi_q <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            sign_q     <= sign_d;
            mode_q     <= mode_d;
            result_q   <= result_d;
            resultHi_q <= resultHi_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    assign BUSY      = (state_q != IDLE);
    assign DONE      = done_q;
    assign RESULT    = result_q;
    assign RESULT_HI = resultHi_q;
    assign OVERFLOW  = overflow_q;

endmodule

// File: tb/tb_n_bits_seq_multiplier.sv
// Scoreboard bench: directed handshake/reset cases on a default instance plus a STEP sweep.
module tb_n_bits_seq_multiplier;
    import n_bits_mult_pkg::*;

    localparam int BITS   = 24;
    localparam int NSTEPS = 8;

    function automatic int stepOf(input int g);
        case (g)
            0:       return 1;
            1:       return 2;
            2:       return 3;
            3:       return 4;
            4:       return 6;
            5:       return 8;
            6:       return 12;
            default: return 24;
        endcase
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    logic            mRst, mStart, mSigned;
    logic [BITS-1:0] mA, mB;
    logic            mBusy, mDone, mOvf;
    logic [BITS-1:0] mRes, mHi;

    n_bits_seq_multiplier #(
        .BITS (BITS),
        .STEP (1)
    ) dut (
        .CLK         (clk),
        .RST         (mRst),
        .START       (mStart),
        .SIGNED_MODE (mSigned),
        .A           (mA),
        .B           (mB),
        .BUSY        (mBusy),
        .DONE        (mDone),
        .RESULT      (mRes),
        .RESULT_HI   (mHi),
        .OVERFLOW    (mOvf)
    );

    logic              sRst, sStart, sSigned;
    logic [BITS-1:0]   sA, sB;
    logic [NSTEPS-1:0] sBusy, sDone, sOvf;
    logic [BITS-1:0]   sRes [NSTEPS];
    logic [BITS-1:0]   sHi  [NSTEPS];

    for (genvar g = 0; g < NSTEPS; g++) begin : gSweep
        n_bits_seq_multiplier #(
            .BITS (BITS),
            .STEP (stepOf(g))
        ) dutS (
            .CLK         (clk),
            .RST         (sRst),
            .START       (sStart),
            .SIGNED_MODE (sSigned),
            .A           (sA),
            .B           (sB),
            .BUSY        (sBusy[g]),
            .DONE        (sDone[g]),
            .RESULT      (sRes[g]),
            .RESULT_HI   (sHi[g]),
            .OVERFLOW    (sOvf[g])
        );
    end

    typedef struct {
        logic [63:0] exp;
        int unsigned startCycle;
    } expect_t;

    expect_t expQ[$];
    expect_t monEntry;

    int checksTotal  = 0;
    int checksPassed = 0;
    int busyCnt;
    int doneCnt;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checksTotal++;
        if (actual === expected) checksPassed++;
        else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    // Reference product {overflow, hi, lo} from plain full-width arithmetic.
    function automatic logic [63:0] refModel(input logic [BITS-1:0] a, input logic [BITS-1:0] b, input logic sm);
        logic signed [2*BITS-1:0] sa, sb;
        logic [2*BITS-1:0]        prod;
        logic                     ovf;
        if (sm) begin
            sa   = {{BITS{a[BITS-1]}}, a};
            sb   = {{BITS{b[BITS-1]}}, b};
            prod = sa * sb;
            ovf  = (prod[2*BITS-1:BITS] != {BITS{prod[BITS-1]}});
        end else begin
            prod = {{BITS{1'b0}}, a} * {{BITS{1'b0}}, b};
            ovf  = (prod[2*BITS-1:BITS] != '0);
        end
        return {15'b0, ovf, prod};
    endfunction

    function automatic logic [63:0] mainPack();
        return {15'b0, mOvf, mHi, mRes};
    endfunction

    always @(negedge clk) begin
        if (mRst && mDone) begin
            checkOutput("doneExpected", 64'(expQ.size() > 0), 64'd1);
            if (expQ.size() > 0) begin
                monEntry = expQ.pop_front();
                checkOutput("scoreboardResult", mainPack(), monEntry.exp);
                checkOutput("doneLatency", 64'(cycle - monEntry.startCycle), 64'(LATENCY(BITS, 1)));
            end
        end
    end

    // Must be called at a negedge; returns at the negedge after the START edge.
    task automatic applyStimulus(input logic [BITS-1:0] a, input logic [BITS-1:0] b, input logic sm);
        expect_t e;
        mA      = a;
        mB      = b;
        mSigned = sm;
        mStart  = 1'b1;
        e.exp        = refModel(a, b, sm);
        e.startCycle = cycle + 1;
        expQ.push_back(e);
        @(negedge clk);
        mStart = 1'b0;
    endtask

    task automatic waitDone(input string tag, output int busyCycles);
        bit seen = 1'b0;
        busyCycles = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (mDone) seen = 1'b1;
            else begin
                if (mBusy) busyCycles++;
                @(negedge clk);
            end
        end
        checkOutput({tag, "_doneSeen"}, 64'(seen), 64'd1);
    endtask

    task automatic runSweep(input int vectors);
        logic [BITS-1:0] a, b;
        logic            sm;
        logic [63:0]     exp;
        int unsigned     startCyc;
        int              seenCnt [NSTEPS];
        logic [BITS-1:0] corners [5];
        corners = '{24'h000000, 24'h000001, 24'h7FFFFF, 24'h800000, 24'hFFFFFF};
        for (int v = 0; v < vectors; v++) begin
            @(negedge clk);
            a  = BITS'($urandom);
            b  = BITS'($urandom);
            sm = 1'($urandom_range(0, 1));
            if (v % 8 == 0) begin
                a = corners[(v / 8) % 5];
                b = corners[(v / 40) % 5];
            end
            sA       = a;
            sB       = b;
            sSigned  = sm;
            sStart   = 1'b1;
            exp      = refModel(a, b, sm);
            startCyc = cycle + 1;
            for (int g = 0; g < NSTEPS; g++) seenCnt[g] = 0;
            @(negedge clk);
            sStart = 1'b0;
            for (int c = 0; c < 27; c++) begin
                for (int g = 0; g < NSTEPS; g++) begin
                    if (sDone[g]) begin
                        seenCnt[g]++;
                        checkOutput($sformatf("sweepS%0d_result", stepOf(g)),
                                    {15'b0, sOvf[g], sHi[g], sRes[g]}, exp);
                        checkOutput($sformatf("sweepS%0d_latency", stepOf(g)),
                                    64'(cycle - startCyc), 64'(LATENCY(BITS, stepOf(g))));
                    end
                end
                @(negedge clk);
            end
            for (int g = 0; g < NSTEPS; g++) begin
                checkOutput($sformatf("sweepS%0d_doneCount", stepOf(g)), 64'(seenCnt[g]), 64'd1);
            end
            checkOutput("sweepIdle", 64'(sBusy), 64'd0);
        end
    endtask

    initial begin
        mRst = 1'b0; mStart = 1'b0; mSigned = 1'b0; mA = '0; mB = '0;
        sRst = 1'b0; sStart = 1'b0; sSigned = 1'b0; sA = '0; sB = '0;
        repeat (3) @(negedge clk);
        checkOutput("resetOutputs", {14'b0, mBusy, mDone, mOvf, mHi, mRes}, 64'd0);
        checkOutput("resetSweepFlags", {40'b0, sBusy, sDone, sOvf}, 64'd0);
        mRst = 1'b1;
        sRst = 1'b1;
        @(negedge clk);

        applyStimulus(24'd3, 24'd5, 1'b0);
        waitDone("u3x5", busyCnt);
        checkOutput("u3x5_busyCycles", 64'(busyCnt), 64'd25);
        checkOutput("u3x5_value", mainPack(), {15'b0, 1'b0, 24'h000000, 24'd15});

        @(negedge clk);
        applyStimulus(24'hFFFFFF, 24'hFFFFFF, 1'b0);
        waitDone("uMax", busyCnt);
        checkOutput("uMax_value", mainPack(), {15'b0, 1'b1, 24'hFFFFFE, 24'h000001});

        @(negedge clk);
        applyStimulus(24'hFFFFF9, 24'd6, 1'b1);
        waitDone("sNeg7x6", busyCnt);
        checkOutput("sNeg7x6_value", mainPack(), {15'b0, 1'b0, 24'hFFFFFF, 24'hFFFFD6});

        @(negedge clk);
        applyStimulus(24'h800000, 24'hFFFFFF, 1'b1);
        waitDone("sMinxNeg1", busyCnt);
        checkOutput("sMinxNeg1_value", mainPack(), {15'b0, 1'b1, 24'h000000, 24'h800000});

        // A second START and operand changes mid-RUN must not disturb the operation.
        @(negedge clk);
        applyStimulus(24'd100, 24'd200, 1'b0);
        repeat (5) @(negedge clk);
        mA = 24'd9; mB = 24'd9; mSigned = 1'b1; mStart = 1'b1;
        @(negedge clk);
        mStart = 1'b0;
        waitDone("midRunStart", busyCnt);
        checkOutput("midRunStart_value", mainPack(), {15'b0, 1'b0, 24'h000000, 24'd20000});

        applyStimulus(24'd1000, 24'd1000, 1'b0);
        checkOutput("holdResultAfterStart", 64'(mRes), 64'd20000);
        checkOutput("busyAfterDoneCycleStart", 64'(mBusy), 64'd1);
        waitDone("backToBack", busyCnt);
        checkOutput("backToBack_busyCycles", 64'(busyCnt), 64'd25);
        checkOutput("backToBack_value", mainPack(), {15'b0, 1'b0, 24'h000000, 24'd1000000});

        @(negedge clk);
        applyStimulus(24'd1234, 24'hFFF000, 1'b1);
        repeat (9) @(negedge clk);
        #2 mRst = 1'b0;
        expQ.delete();
        #1 checkOutput("midRunReset", {14'b0, mBusy, mDone, mOvf, mHi, mRes}, 64'd0);
        @(negedge clk);
        mRst = 1'b1;
        doneCnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mDone) doneCnt++;
        end
        checkOutput("noDoneAfterReset", 64'(doneCnt), 64'd0);

        applyStimulus(24'hFFFFFB, 24'd0, 1'b1);
        waitDone("sZero", busyCnt);
        checkOutput("sZero_busyCycles", 64'(busyCnt), 64'd25);
        checkOutput("sZero_value", mainPack(), 64'd0);

        runSweep(1000);

        repeat (2) @(negedge clk);
        checkOutput("scoreboardDrained", 64'(expQ.size()), 64'd0);
        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
